rca_seq: RTL
============

Name: rca_seq

Overview:
- Multi-cycle, parametrised ripple-carry adder/subtractor: adds a CHUNK-bit slice per clock over BITS/CHUNK cycles, trading latency for a short carry chain.
- Start/busy/done handshake; carry chain registered between slices.
- Adds subtract mode and signed-overflow detection.
- Drop-in sequential arithmetic unit for datapaths where a full BITS-wide combinational ripple chain cannot meet timing.

Parameters:
- BITS, 32, operand/result width; must be a multiple of CHUNK.
- CHUNK, 8, bits processed per cycle, 1 <= CHUNK <= BITS; N = BITS/CHUNK cycles per operation.

Ports:
- _clk  input  1  clock, rising edge.
- _rst  input  1  synchronous active-high reset.
- _start  input  1  request; sampled only when _busy=0.
- _sub  input  1  0 = add, 1 = subtract (A - B); sampled with _start.
- _a_in  input  BITS  operand A; sampled with _start.
- _b_in  input  BITS  operand B; sampled with _start.
- _c_in  input  1  carry-in (add) or borrow-in (sub); sampled with _start.
- _busy  output  1  operation in progress.
- _done  output  1  one-cycle pulse; results valid.
- _s_out  output  BITS  sum/difference, registered.
- _c_out  output  1  raw carry out of MSB.
- _ovf_out  output  1  two's-complement signed overflow.

Behaviour:
- Reset (synchronous, active-high): state IDLE. _busy=0, _done=0, _s_out=0, _c_out=0, _ovf_out=0. Slice index=0. Operand registers cleared.
- Reset mid-operation: aborts immediately. Partial result discarded. No _done pulse.
- States:
  - IDLE: _start=1 -> RUN.
  - RUN: iterates slice index 0..N-1; after slice N-1 -> DONE.
  - DONE: lasts exactly one cycle. _start=1 -> RUN; else -> IDLE.
- Accept edge (_start=1 in IDLE or DONE):
  - latch A.
  - latch B' = _sub ? ~_b_in : _b_in.
  - latch carry register = _sub ? ~_c_in : _c_in. In sub mode _c_in=1 means borrow, so A - B - 1.
  - latch op flag; slice index=0; _busy=1 from next cycle.
- RUN, each edge, slice k (bits k*CHUNK .. k*CHUNK+CHUNK-1):
  - per-bit full-adder ripple within the slice, seeded by the carry register.
  - write the sum slice into the result register at the same position.
  - carry register <= slice carry-out; k increments.
- Last slice edge:
  - _c_out <= MSB carry-out.
  - _ovf_out <= carry-into-MSB XOR carry-out-of-MSB.
  - _busy <= 0; _done <= 1.
- Timing:
  - _done rises N edges after the accepting edge; _busy is high for exactly N cycles.
  - N=1 (CHUNK=BITS): _done the cycle after accept.
- Result hold: _s_out/_c_out/_ovf_out update only at the final slice edge and hold until the next completion. During RUN, _s_out holds the previous result, not partial slices.
- Handshake rules:
  - _start while _busy=1 is ignored; no queuing, no effect on the in-flight operation.
  - Input changes after accept have no effect.
  - _start held high continuously: back-to-back operations, one _done per N+1 cycles (DONE cycle accepts).
- Arithmetic:
  - Result is modulo 2^BITS.
  - Sub mode: _c_out=1 means no borrow.
  - _ovf_out is meaningful in both modes.

Test Plan:
- BITS=32, CHUNK=8: reset, then start add A=0x0000_00FF, B=0x0000_0001, _c_in=0 -> _busy high 4 cycles, _done pulse at edge 4 after accept; _s_out=0x0000_0100, _c_out=0, _ovf_out=0.
- Carry across all slices: A=0xFFFF_FFFF, B=0, _c_in=1 -> _s_out=0, _c_out=1, _ovf_out=0.
- Signed overflow and subtract:
  - add A=0x7FFF_FFFF, B=1 -> _s_out=0x8000_0000, _ovf_out=1, _c_out=0.
  - sub A=5, B=7, _c_in=0 -> _s_out=0xFFFF_FFFE, _c_out=0, _ovf_out=0.
  - sub A=0x8000_0000, B=1 -> _s_out=0x7FFF_FFFF, _ovf_out=1, _c_out=1.
- _start pulsed at cycle 2 of RUN with different operands -> ignored; first result unaffected; exactly one _done. With _start held high: consecutive _done pulses spaced 5 cycles apart.
- Assert _rst at RUN cycle 2 -> next cycle all outputs 0, state IDLE, no _done; a fresh operation afterwards completes correctly.
- Parameter sweep (BITS,CHUNK) = (32,1), (32,32), (16,4), (8,8): 1000 random add/sub each vs reference model; latency checked = N.

Source files
------------

// File: rtl/rca_seq.sv
// Sequential ripple-carry adder/subtractor: one CHUNK-bit slice per clock,
// carry held in a register between slices, signed overflow at the MSB.
module rca_seq #(
  parameter int BITS  = 32,
  parameter int CHUNK = 8
) (
  input  logic            _clk,
  input  logic            _rst,
  input  logic            _start,
  input  logic            _sub,
  input  logic [BITS-1:0] _a_in,
  input  logic [BITS-1:0] _b_in,
  input  logic            _c_in,
  output logic            _busy,
  output logic            _done,
  output logic [BITS-1:0] _s_out,
  output logic            _c_out,
  output logic            _ovf_out
);

  localparam int N     = BITS / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [BITS-1:0]   a_r;
  logic [BITS-1:0]   b_r;
  logic [BITS-1:0]   work_r;
  logic [BITS-1:0]   work_nxt;
  logic              cy_r;
  logic [IDX_W-1:0]  idx;
  logic [CHUNK-1:0]  a_sl;
  logic [CHUNK-1:0]  b_sl;
  logic [CHUNK-1:0]  sum_sl;
  logic              c_msb_in;
  logic              c_sl_out;
  logic              accept;
  int                base;

  // Returns {carry into top bit, carry out of top bit, sum}.
  function automatic logic [CHUNK+1:0] slice_add(input logic [CHUNK-1:0] a,
                                                 input logic [CHUNK-1:0] b,
                                                 input logic             cin);
    logic [CHUNK:0]   c;
    logic [CHUNK-1:0] s;
    c[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    return {c[CHUNK-1], c[CHUNK], s};
  endfunction

  always_comb begin
    base = int'(idx) * CHUNK;
    a_sl = a_r[base +: CHUNK];
    b_sl = b_r[base +: CHUNK];
    {c_msb_in, c_sl_out, sum_sl} = slice_add(a_sl, b_sl, cy_r);
    work_nxt = work_r;
    work_nxt[base +: CHUNK] = sum_sl;
  end

  // The DONE cycle may accept a new request, giving one result per N+1 cycles.
  assign accept = _start && (state != RUN);

  always_ff @(posedge _clk) begin
    if (_rst) begin
      state    <= IDLE;
      _busy    <= 1'b0;
      _done    <= 1'b0;
      _s_out   <= '0;
      _c_out   <= 1'b0;
      _ovf_out <= 1'b0;
      idx      <= '0;
      a_r      <= '0;
      b_r      <= '0;
      work_r   <= '0;
      cy_r     <= 1'b0;
    end else if (accept) begin
      a_r   <= _a_in;
      b_r   <= _sub ? ~_b_in : _b_in;
      cy_r  <= _sub ^ _c_in;
      idx   <= '0;
      _busy <= 1'b1;
      _done <= 1'b0;
      state <= RUN;
    end else begin
      case (state)
        RUN: begin
          cy_r   <= c_sl_out;
          work_r <= work_nxt;
          idx    <= idx + 1'b1;
          if (idx == LAST) begin
            // Results are published only here so _s_out never shows partial slices.
            _s_out   <= work_nxt;
            _c_out   <= c_sl_out;
            _ovf_out <= c_msb_in ^ c_sl_out;
            _busy    <= 1'b0;
            _done    <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          _done <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
